// File: rtl/wb_arb_pkg.sv
// ------------------------------------------------------------------
// wb_arb_pkg : shared types and helpers for the Wishbone arbiters. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package wb_arb_pkg;

  localparam int MAX_NM     = 8;
  localparam int IDX_W      = 3;
  localparam int OW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Saturation value of an ow-bit outstanding counter.
  function automatic int cnt_max(input int ow);
    return (1 << ow) - 1;
  endfunction

  // First requester after 'last', scanning cyclically over nm masters.
  function automatic pick_t rr_pick(input logic [MAX_NM-1:0] req,
                                    input logic [IDX_W-1:0]  last,
                                    input int                nm);
    pick_t            res;
    logic [IDX_W-1:0] ci;
    res = '0;
    for (int k = MAX_NM; k >= 1; k--) begin
      if (k <= nm) begin
        ci = IDX_W'((int'(last) + k) % nm);
        if (req[ci]) begin
          res.valid = 1'b1;
          res.idx   = ci;
        end
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_pick.sv
// ------------------------------------------------------------------
// wb_rr_pick : combinational round-robin priority encoder. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter  int NM = 4,
  localparam int IW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [MAX_NM-1:0] req_ext;
  logic [IDX_W-1:0]  last_ext;
  pick_t             pick;

  always_comb begin
    req_ext         = '0;
    req_ext[NM-1:0] = req;
    last_ext        = IDX_W'(last);
    pick            = rr_pick(req_ext, last_ext, NM);
    idx             = pick.idx[IW-1:0];
    valid           = pick.valid;
  end

endmodule

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ------------------------------------------------------------------
// wb_rr_arbiter : N:1 pipelined Wishbone round-robin arbiter with watchdog. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023,
  parameter int OW      = OW_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NM-1:0]        m_cyc,
  input  logic [NM-1:0]        m_stb,
  input  logic [NM-1:0]        m_we,
  input  logic [NM*AW-1:0]     m_adr,
  input  logic [NM*DW-1:0]     m_dat,
  input  logic [NM*DW/8-1:0]   m_sel,
  output logic [NM-1:0]        m_stall,
  output logic [NM-1:0]        m_ack,
  output logic [NM-1:0]        m_err,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [AW-1:0]        s_adr,
  output logic [DW-1:0]        s_dat,
  output logic [DW/8-1:0]      s_sel,
  input  logic                 s_stall,
  input  logic                 s_ack,
  input  logic                 s_err,
  output logic [NM-1:0]        grant
);

  localparam int            IW      = $clog2(NM);
  localparam int            SW      = DW / 8;
  localparam int            WW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OW-1:0] CNT_MAX = OW'(cnt_max(OW));

  arb_state_e    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          own, owner_cyc, sat, accept, resp, dec, wd_fire;

  wb_rr_pick #(.NM(NM)) u_pick (
    .req   (m_cyc),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NM - 1);
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  // Slave-side mux and per-master response routing.
  always_comb begin
    own       = (state_q == OWN);
    owner_cyc = own && m_cyc[owner_q];
    sat       = (cnt_q == CNT_MAX);
    s_cyc     = owner_cyc;
    s_stb     = owner_cyc && m_stb[owner_q] && !sat;
    s_we      = owner_cyc && m_we[owner_q];
    s_adr     = owner_cyc ? m_adr[owner_q*AW +: AW] : '0;
    s_dat     = owner_cyc ? m_dat[owner_q*DW +: DW] : '0;
    s_sel     = owner_cyc ? m_sel[owner_q*SW +: SW] : '0;
    m_stall   = '1;
    m_ack     = '0;
    m_err     = '0;
    grant     = '0;
    if (own) begin
      grant[owner_q]   = 1'b1;
      m_stall[owner_q] = s_stall || sat;
      if (owner_cyc) begin
        m_ack[owner_q] = s_ack;
        m_err[owner_q] = s_err;
      end
    end
    if (state_q == ABORT) begin
      grant[owner_q] = 1'b1;
      m_err[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    accept  = s_stb && !s_stall;
    resp    = owner_cyc && (s_ack || s_err);
    dec     = resp && (cnt_q != '0);
    wd_fire = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        wd_d  = '0;
        if (pick_valid) begin
          owner_d = pick_idx;
          state_d = OWN;
        end
      end
      OWN: begin
        if (!m_cyc[owner_q]) begin
          // Release abandons anything still in flight.
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
          wd_d    = '0;
        end else begin
          if (accept && !dec) begin
            cnt_d = cnt_q + 1'b1;
          end else if (!accept && dec) begin
            cnt_d = cnt_q - 1'b1;
          end
          if (resp || cnt_q == '0 || TIMEOUT == 0) begin
            wd_d = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
          wd_fire = (TIMEOUT != 0) && (wd_d == WW'(TIMEOUT));
          if (wd_fire) begin
            state_d = ABORT;
            cnt_d   = '0;
            wd_d    = '0;
          end
        end
      end
      ABORT: begin
        state_d = IDLE;
        last_d  = owner_q;
        cnt_d   = '0;
        wd_d    = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
// ------------------------------------------------------------------
// tb_wb_rr_arbiter : directed self-checking bench for wb_rr_arbiter. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = DW / 8;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*SW-1:0]  m_sel;
  logic [NM-1:0]     m_stall, m_ack, m_err;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat;
  logic [SW-1:0]     s_sel;
  logic              s_stall, s_ack, s_err;
  logic [NM-1:0]     grant;

  int vecs    = 0;
  int miscmp  = 0;

  always #5 CLK = ~CLK;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(8), .OW(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel),
    .m_stall(m_stall), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel),
    .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err),
    .grant(grant)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic zero_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    zero_inputs();
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic idle_out();
    zero_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    zero_inputs();
    m_cyc = 4'hF;
    m_stb = 4'hF;
    tick();
    #1;
    vecs++; if (grant !== 4'b0000) begin miscmp++; $display("FAIL reset_grant: got %b want 0000", grant); end
    vecs++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin miscmp++; $display("FAIL reset_strobes: got %b want 000", {s_cyc, s_stb, s_we}); end
    vecs++; if (m_stall !== 4'b1111) begin miscmp++; $display("FAIL reset_stall: got %b want 1111", m_stall); end
    vecs++; if ({m_ack, m_err} !== 8'h00) begin miscmp++; $display("FAIL reset_ack_err: got %h want 00", {m_ack, m_err}); end
    vecs++; if (s_adr !== 16'h0) begin miscmp++; $display("FAIL reset_adr: got %h want 0000", s_adr); end
    m_cyc = '0;
    m_stb = '0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int acks = 0;
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100; m_we = 4'b0100;
    m_adr[2*AW +: AW] = 16'h2A00;
    m_dat[2*DW +: DW] = 16'hBEEF;
    m_sel[2*SW +: SW] = 2'b10;
    #1;
    vecs++; if (s_cyc !== 1'b0) begin miscmp++; $display("FAIL single_latency: s_cyc got %b want 0", s_cyc); end
    tick(); #1;
    vecs++; if (grant !== 4'b0100) begin miscmp++; $display("FAIL single_grant: got %b want 0100", grant); end
    vecs++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin miscmp++; $display("FAIL single_strobes: got %b want 111", {s_cyc, s_stb, s_we}); end
    vecs++; if ({s_adr, s_dat, s_sel} !== {16'h2A00, 16'hBEEF, 2'b10}) begin miscmp++; $display("FAIL single_mux: got %h/%h/%b want 2a00/beef/10", s_adr, s_dat, s_sel); end
    vecs++; if (m_stall !== 4'b1011) begin miscmp++; $display("FAIL single_stall: got %b want 1011", m_stall); end
    for (int c = 2; c <= 5; c++) begin
      tick();
      s_ack    = (c <= 4);
      m_stb[2] = (c <= 3);
      #1;
      if (m_ack == 4'b0100) acks++;
    end
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    #1;
    vecs++; if (acks !== 3) begin miscmp++; $display("FAIL single_acks: got %0d want 3", acks); end
    vecs++; if (s_cyc !== 1'b0) begin miscmp++; $display("FAIL single_release: s_cyc got %b want 0", s_cyc); end
    tick();
    s_ack = 1'b1;
    #1;
    vecs++; if ({grant, m_ack} !== 8'h00) begin miscmp++; $display("FAIL single_late_ack: grant/ack got %b/%b want 0000/0000", grant, m_ack); end
    idle_out();
  endtask

  task automatic test_rr();
    int         nbeat[4];
    int         nack[4];
    logic       drop[4];
    logic [3:0] order[$];
    logic [3:0] exp_o[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prev_g = '0;
    logic       acc;
    int         idle = 0;
    int         n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin nbeat[i] = 0; nack[i] = 0; drop[i] = 1'b0; end
    m_cyc = 4'hF; m_stb = 4'hF;
    #1;
    while (order.size() < 5 && n < 80) begin
      acc = s_stb && !s_stall;
      for (int i = 0; i < 4; i++) begin
        if (m_ack[i]) nack[i]++;
        if (m_stb[i] && !m_stall[i]) nbeat[i]++;
      end
      if (grant != 4'b0 && prev_g == 4'b0) order.push_back(grant);
      if (grant == 4'b0 && order.size() >= 1 && order.size() < 5) idle++;
      prev_g = grant;
      tick();
      n++;
      s_ack = acc;
      for (int i = 0; i < 4; i++) begin
        if (drop[i]) begin
          drop[i] = 1'b0; m_cyc[i] = 1'b1; m_stb[i] = 1'b1; nbeat[i] = 0; nack[i] = 0;
        end else if (nack[i] == 2) begin
          m_cyc[i] = 1'b0; m_stb[i] = 1'b0; drop[i] = 1'b1;
        end else begin
          m_stb[i] = (nbeat[i] < 2);
        end
      end
      #1;
    end
    vecs++;
    if (order.size() != 5) begin
      miscmp++; $display("FAIL rr_timeout: got %0d grants want 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (k > 0) vecs++;
        if (order[k] !== exp_o[k]) begin miscmp++; $display("FAIL rr_order[%0d]: got %b want %b", k, order[k], exp_o[k]); end
      end
    end
    vecs++; if (idle !== 4) begin miscmp++; $display("FAIL rr_idle_gaps: got %0d want 4", idle); end
    idle_out();
  endtask

  task automatic test_stall();
    logic [3:0] exp_stall;
    do_reset();
    m_cyc = 4'b0010; m_stb = 4'b0010;
    #1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      s_stall = (c <= 3);
      #1;
      exp_stall = (c <= 3) ? 4'b1111 : 4'b1101;
      vecs++; if (m_stall !== exp_stall) begin miscmp++; $display("FAIL stall_c%0d: got %b want %b", c, m_stall, exp_stall); end
    end
    vecs++; if (dut.cnt_q !== 2'd0) begin miscmp++; $display("FAIL stall_cnt_held: got %0d want 0", dut.cnt_q); end
    tick();
    s_stall = 1'b0; m_stb = '0;
    #1;
    vecs++; if (dut.cnt_q !== 2'd1) begin miscmp++; $display("FAIL stall_cnt_inc: got %0d want 1", dut.cnt_q); end
    idle_out();
  endtask

  task automatic test_timeout();
    int bad = 0;
    do_reset();
    m_cyc = 4'b1000; m_stb = 4'b1000;
    #1;
    tick(); #1;
    vecs++; if ({grant, s_stb} !== 5'b10001) begin miscmp++; $display("FAIL to_accept: grant/stb got %b/%b want 1000/1", grant, s_stb); end
    for (int c = 2; c <= 9; c++) begin
      tick();
      m_stb = '0; m_cyc = 4'b1010;
      #1;
      if (m_err !== 4'b0 || s_cyc !== 1'b1) bad++;
    end
    vecs++; if (bad !== 0) begin miscmp++; $display("FAIL to_early: got %0d bad cycles want 0", bad); end
    tick(); #1;
    vecs++; if (m_err !== 4'b1000) begin miscmp++; $display("FAIL to_err: got %b want 1000", m_err); end
    vecs++; if ({s_cyc, s_stb} !== 2'b00) begin miscmp++; $display("FAIL to_abort_cyc: got %b want 00", {s_cyc, s_stb}); end
    tick(); #1;
    vecs++; if (grant !== 4'b0000) begin miscmp++; $display("FAIL to_idle: grant got %b want 0000", grant); end
    tick(); #1;
    vecs++; if ({grant, s_cyc} !== 5'b00101) begin miscmp++; $display("FAIL to_next: grant/cyc got %b/%b want 0010/1", grant, s_cyc); end
    idle_out();
  endtask

  task automatic test_saturation();
    do_reset();
    m_cyc = 4'b0001; m_stb = 4'b0001;
    #1;
    tick(); tick(); tick(); #1;
    vecs++; if ({m_stall, s_stb} !== 5'b11101) begin miscmp++; $display("FAIL sat_third: stall/stb got %b/%b want 1110/1", m_stall, s_stb); end
    tick(); #1;
    vecs++; if ({m_stall, s_stb} !== 5'b11110) begin miscmp++; $display("FAIL sat_full: stall/stb got %b/%b want 1111/0", m_stall, s_stb); end
    tick(); #1;
    vecs++; if (s_stb !== 1'b0) begin miscmp++; $display("FAIL sat_hold: s_stb got %b want 0", s_stb); end
    tick();
    s_ack = 1'b1;
    #1;
    vecs++; if ({m_stall, m_ack} !== 8'b1111_0001) begin miscmp++; $display("FAIL sat_ack: stall/ack got %b/%b want 1111/0001", m_stall, m_ack); end
    tick();
    s_ack = 1'b0;
    #1;
    vecs++; if ({m_stall, s_stb} !== 5'b11101) begin miscmp++; $display("FAIL sat_release: stall/stb got %b/%b want 1110/1", m_stall, s_stb); end
    idle_out();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cyc = 4'b0100; m_stb = 4'b0100;
    #1;
    tick(); tick();
    tick();
    m_stb = '0; nRST = 1'b0;
    #1;
    vecs++; if (dut.cnt_q !== 2'd2) begin miscmp++; $display("FAIL rst_mid_cnt: got %0d want 2", dut.cnt_q); end
    tick();
    nRST = 1'b1; s_ack = 1'b1;
    #1;
    vecs++; if ({grant, s_cyc} !== 5'b00000) begin miscmp++; $display("FAIL rst_mid_state: grant/cyc got %b/%b want 0000/0", grant, s_cyc); end
    vecs++; if ({m_stall, m_ack} !== 8'b1111_0000) begin miscmp++; $display("FAIL rst_mid_late_ack: stall/ack got %b/%b want 1111/0000", m_stall, m_ack); end
    tick();
    s_ack = 1'b0;
    #1;
    vecs++; if ({grant, s_cyc} !== 5'b01001) begin miscmp++; $display("FAIL rst_mid_resume: grant/cyc got %b/%b want 0100/1", grant, s_cyc); end
    idle_out();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone (pipelined) round-robin arbiter with bus locking and a watchdog timeout.
- Sits between several Wishbone masters (CPU ports, DMA engines) and one shared slave port, alongside the 2:1 fixed-priority arbiter.
- Grant is held for a master's whole cyc; an outstanding-transaction counter plus a timeout guarantees a hung slave cannot lock the bus.

Parameters:
- NM, 4, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width; sel width = DW/8.
- TIMEOUT, 1023, max cycles an owner may wait with outstanding>0 and no ack/err; 0 disables the watchdog.
- OW, 4, outstanding-counter width (max 2^OW-1 in flight).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; synchronous, active-low; clock CLK
- m_cyc  in  NM  per-master cyc
- m_stb  in  NM  per-master stb
- m_we  in  NM  per-master we
- m_adr  in  NM*AW  packed addresses; master i at [i*AW +: AW]
- m_dat  in  NM*DW  packed write data
- m_sel  in  NM*DW/8  packed byte selects
- m_stall  out  NM  per-master stall
- m_ack  out  NM  per-master ack
- m_err  out  NM  per-master err
- s_cyc, s_stb, s_we  out  1  slave strobes
- s_adr  out  AW; s_dat  out  DW; s_sel  out  DW/8  muxed slave request
- s_stall, s_ack, s_err  in  1  slave responses
- grant  out  NM  one-hot current owner; 0 when no owner (debug/perf)

Behaviour:
- States: IDLE, OWN, ABORT. Registers: state, owner index, last-owner pointer, outstanding count, watchdog count.
- Reset: state=IDLE, owner=0, last=NM-1, counts=0, grant=0. All outputs 0 except m_stall = all-ones.
- IDLE: when any m_cyc=1, pick the first requester scanning from last+1 cyclically; register it as owner and go to OWN. Grant latency is exactly 1 cycle (s_cyc rises the cycle after m_cyc is first seen).
- OWN:
  - s_cyc = m_cyc[owner]; s_stb = m_stb[owner]; adr/dat/sel/we muxed from owner.
  - m_stall[owner] = s_stall; all others see stall = 1.
  - m_ack[owner] = s_ack and m_err[owner] = s_err; non-owners see 0.
  - When m_cyc[owner] falls: go to IDLE, set last = owner, clear counts. s_cyc drops the same cycle (combinational). A new grant can be issued in IDLE the following cycle.
- Outstanding count:
  - +1 on s_stb && !s_stall.
  - -1 on s_ack || s_err.
  - Both in the same cycle: unchanged.
  - Saturates at 2^OW-1. While saturated, the owner is forced to stall (stall = 1) and s_stb is masked.
  - An ack/err with count=0 is forwarded but does not decrement.
- Watchdog:
  - Counts cycles while count > 0 with no ack/err; resets on any ack/err, or when count = 0.
  - When it reaches TIMEOUT: go to ABORT.
- ABORT (lasts 1 cycle): s_cyc = 0, s_stb = 0; m_err[owner] = 1 for that cycle; counts cleared.
  - Next state: IDLE, with last = owner.
  - If the owner keeps m_cyc asserted, it re-competes fairly; it is not re-granted ahead of other pending masters.
- A master dropping m_cyc mid-burst while count > 0 abandons its transactions. Late s_ack/s_err arriving after release are dropped (not routed to any master).
- Simultaneous release and new requests: no grant in the release cycle. Round-robin order is preserved.
- nRST asserted mid-transfer: next edge forces the reset state; the slave sees s_cyc=0 immediately after that edge.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum (IDLE/OWN/ABORT);
  - a function rr_pick(req, last) returning the next owner index and a valid flag;
  - a localparam for the counter max.
- One natural sub-module, wb_rr_pick: combinational round-robin priority encoder, parameterised by NM. It is reusable by other arbiters.
- The datapath mux is an indexed part-select; no further sub-modules.

Test Plan:
- Single master: NM=4; m_cyc[2] held 6 cycles with 3 stb, slave acks each 1 cycle later -> grant=4'b0100 from cycle 2, 3 acks on m_ack[2], s_cyc drops the cycle m_cyc[2] falls.
- Round-robin fairness: all 4 masters request continuously, each burst 2 beats -> grant order 0,1,2,3,0; no master waits more than 3 bursts; one idle cycle between owners.
- Stall isolation: owner 1 active, s_stall=1 for 3 cycles -> m_stall[1]=1 only during those cycles; m_stall[0,2,3]=1 throughout; count increments only on non-stalled stb.
- Timeout: TIMEOUT=8, owner 3 issues 1 stb, slave never acks -> m_err[3]=1 exactly at cycle 9 after acceptance, s_cyc=0 that cycle, then the next pending master is granted.
- Saturation: OW=2, slave delays acks -> after 3 accepted stb, m_stall[owner]=1 and s_stb=0 until the first ack.
- Reset mid-burst: nRST=0 for 1 cycle while count=2 -> grant=0, s_cyc=0, m_stall all-ones next cycle; a late s_ack is dropped; normal arbitration resumes afterwards.
